// File: rtl/spi_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated SPI master.
package spi_arb_pkg;

    localparam int SPI_BITS = 8;
    localparam int MAX_REQ  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_WAIT,
        ST_HOLD,
        ST_GAP
    } spi_arb_state_e;

    // Returns {found, index}; scanning from the top down lets the entry closest to ptr win.
    function automatic logic [3:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         ptr,
                                           input int                 num_req);
        logic [3:0] pick;
        int         idx;
        pick = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < num_req) begin
                idx = (int'(ptr) + i) % num_req;
                if (valid[idx[2:0]]) begin
                    pick = {1'b1, idx[2:0]};
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; the pointer moves past the winner on each accepted grant.
module spi_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               io_clock,
    input  logic               io_resetn,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant,
    output logic [2:0]         grant_idx
);
    import spi_arb_pkg::*;

    logic [2:0]         ptr_q;
    logic [2:0]         ptr_d;
    logic [MAX_REQ-1:0] valid_ext;
    logic [3:0]         pick;

    always_comb begin
        valid_ext                = '0;
        valid_ext[NUM_REQ-1:0]   = req_valid;
        pick                     = rr_pick(valid_ext, ptr_q, NUM_REQ);
        grant_idx                = pick[2:0];
        grant                    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = pick[3] && (pick[2:0] == 3'(i));
        end
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (int'(pick[2:0]) == NUM_REQ - 1) ? 3'd0 : pick[2:0] + 3'd1;
        end
    end

    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/spi_arbiter_master.sv
// Mode-0 MSB-first SPI master shared by NUM_REQ requesters; each owner keeps SS low for its whole burst.
module spi_arbiter_master #(
    parameter int NUM_REQ = 2,
    parameter int CLK_DIV = 4
) (
    input  logic                 io_clock,
    input  logic                 io_resetn,
    input  logic [NUM_REQ-1:0]   io_req_valid,
    output logic [NUM_REQ-1:0]   io_req_ready,
    input  logic [NUM_REQ*8-1:0] io_req_data,
    input  logic [NUM_REQ-1:0]   io_req_last,
    output logic [NUM_REQ-1:0]   io_rsp_valid,
    output logic [7:0]           io_rsp_data,
    output logic                 io_spi_sclk,
    output logic                 io_spi_ss,
    output logic                 io_spi_mosi,
    input  logic                 io_spi_miso
);
    import spi_arb_pkg::*;

    localparam int               DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    spi_arb_state_e     state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         tx_q, tx_d;
    logic [7:0]         rx_q, rx_d;
    logic [2:0]         owner_q, owner_d;
    logic               last_q, last_d;
    logic               sclk_q, sclk_d;
    logic               ss_q, ss_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] grant;
    logic [2:0]         grant_idx;
    logic [2:0]         sel_idx;
    logic [7:0]         sel_data;
    logic               sel_last;
    logic               handshake;
    logic               advance;

    spi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .io_clock  (io_clock),
        .io_resetn (io_resetn),
        .req_valid (io_req_valid),
        .advance   (advance),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // In WAIT only the current owner may continue its burst; everyone else is blocked.
    always_comb begin
        io_req_ready = '0;
        if (io_resetn) begin
            if (state_q == ST_IDLE) begin
                io_req_ready = grant;
            end else if (state_q == ST_WAIT) begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    io_req_ready[i] = (owner_q == 3'(i)) && io_req_valid[i];
                end
            end
        end
        handshake = |(io_req_ready & io_req_valid);
        advance   = handshake && (state_q == ST_IDLE);
        sel_idx   = (state_q == ST_IDLE) ? grant_idx : owner_q;
        sel_data  = '0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == 3'(i)) begin
                sel_data = io_req_data[8*i +: 8];
                sel_last = io_req_last[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        owner_d     = owner_q;
        last_d      = last_q;
        sclk_d      = sclk_q;
        ss_d        = ss_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;

        if ((state_q == ST_IDLE || state_q == ST_WAIT) && handshake) begin
            if (state_q == ST_IDLE) begin
                owner_d = grant_idx;
            end
            tx_d    = sel_data;
            last_d  = sel_last;
            ss_d    = 1'b0;
            sclk_d  = 1'b0;
            div_d   = DIV_LOAD;
            state_d = ST_SETUP;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    ss_d   = 1'b1;
                    sclk_d = 1'b0;
                end
                ST_SETUP: begin
                    if (div_q == '0) begin
                        div_d   = DIV_LOAD;
                        bit_d   = '0;
                        state_d = ST_SHIFT;
                    end else begin
                        div_d = div_q - DIV_W'(1);
                    end
                end
                // The rx byte is complete at the end of the last high phase, so it is reported as-is.
                ST_SHIFT: begin
                    if (div_q == '0) begin
                        div_d = DIV_LOAD;
                        if (!sclk_q) begin
                            sclk_d = 1'b1;
                            rx_d   = {rx_q[6:0], io_spi_miso};
                        end else begin
                            sclk_d = 1'b0;
                            if (bit_q == 3'(SPI_BITS - 1)) begin
                                for (int i = 0; i < NUM_REQ; i++) begin
                                    rsp_valid_d[i] = (owner_q == 3'(i));
                                end
                                rsp_data_d = rx_q;
                                state_d    = last_q ? ST_HOLD : ST_WAIT;
                            end else begin
                                bit_d = bit_q + 3'd1;
                                tx_d  = {tx_q[6:0], 1'b0};
                            end
                        end
                    end else begin
                        div_d = div_q - DIV_W'(1);
                    end
                end
                ST_WAIT: begin
                    sclk_d = 1'b0;
                end
                ST_HOLD: begin
                    if (div_q == '0) begin
                        ss_d    = 1'b1;
                        div_d   = DIV_LOAD;
                        state_d = ST_GAP;
                    end else begin
                        div_d = div_q - DIV_W'(1);
                    end
                end
                ST_GAP: begin
                    if (div_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        div_d = div_q - DIV_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge io_clock or negedge io_resetn) begin
        if (!io_resetn) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            owner_q     <= '0;
            last_q      <= 1'b0;
            sclk_q      <= 1'b0;
            ss_q        <= 1'b1;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            sclk_q      <= sclk_d;
            ss_q        <= ss_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign io_spi_sclk  = sclk_q;
    assign io_spi_ss    = ss_q;
    assign io_spi_mosi  = tx_q[7];
    assign io_rsp_valid = rsp_valid_q;
    assign io_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_arbiter_master.sv
// Directed scoreboard bench for spi_arbiter_master: two requesters at CLK_DIV=2 plus a CLK_DIV=1 instance.
module tb_spi_arbiter_master;

    localparam int D       = 2;
    localparam int RSP_LAT = 1 + 17 * D;

    typedef struct {
        int         idx;
        logic [7:0] data;
        int         due;
    } expRsp_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic [1:0]  reqValid, reqReady, reqLast, rspValid;
    logic [15:0] reqData;
    logic [7:0]  rspData;
    logic        sclk, ss, mosi, miso;
    int          misoMode;

    logic [1:0]  bValid, bReady, bLast, bRspValid;
    logic [15:0] bData;
    logic [7:0]  bRspData;
    logic        bSclk, bSs, bMosi;

    int          cyc   = 0;
    int          total = 0;
    int          bad   = 0;
    expRsp_t     sb[$];
    expRsp_t     monE;
    logic [7:0]  mosiCap     = 8'h00;
    logic        sclkPrev    = 1'b0;
    logic        watch       = 1'b0;
    logic        ssHighSeen  = 1'b0;
    logic        r1ReadySeen = 1'b0;

    assign miso = (misoMode == 0) ? mosi : (misoMode == 1);

    spi_arbiter_master #(.NUM_REQ(2), .CLK_DIV(D)) dut (
        .io_clock     (clk),
        .io_resetn    (rstN),
        .io_req_valid (reqValid),
        .io_req_ready (reqReady),
        .io_req_data  (reqData),
        .io_req_last  (reqLast),
        .io_rsp_valid (rspValid),
        .io_rsp_data  (rspData),
        .io_spi_sclk  (sclk),
        .io_spi_ss    (ss),
        .io_spi_mosi  (mosi),
        .io_spi_miso  (miso)
    );

    spi_arbiter_master #(.NUM_REQ(2), .CLK_DIV(1)) dutFast (
        .io_clock     (clk),
        .io_resetn    (rstN),
        .io_req_valid (bValid),
        .io_req_ready (bReady),
        .io_req_data  (bData),
        .io_req_last  (bLast),
        .io_rsp_valid (bRspValid),
        .io_rsp_data  (bRspData),
        .io_spi_sclk  (bSclk),
        .io_spi_ss    (bSs),
        .io_spi_mosi  (bMosi),
        .io_spi_miso  (bMosi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Response monitor: every rsp pulse must match the oldest scoreboard entry, including its cycle.
    always @(negedge clk) begin
        if (sclk && !sclkPrev) mosiCap = {mosiCap[6:0], mosi};
        sclkPrev = sclk;
        if (watch) begin
            if (ss) ssHighSeen = 1'b1;
            if (reqReady[1]) r1ReadySeen = 1'b1;
        end
        if (rspValid !== 2'b00) begin
            checkOutput("rsp_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                monE = sb.pop_front();
                checkOutput("rsp_valid_vec", 32'(rspValid), 32'(2'b01 << monE.idx));
                checkOutput("rsp_data", 32'(rspData), 32'(monE.data));
                checkOutput("rsp_cycle", cyc, monE.due);
            end
        end
    end

    task automatic waitHandshake(output int hs);
        int   n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        #1;
        while (!ok && n < 2000) begin
            if ((reqReady & reqValid) != 2'b00) ok = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        hs = cyc;
        checkOutput("handshake_seen", 32'(ok), 32'd1);
    endtask

    task automatic applyStimulus(input int r, input logic [7:0] d, input logic l,
                                 input logic [7:0] expRx, output int hs);
        expRsp_t e;
        reqData[r*8 +: 8] = d;
        reqLast[r]        = l;
        reqValid[r]       = 1'b1;
        waitHandshake(hs);
        checkOutput("ready_grant", 32'(reqReady), 32'(2'b01 << r));
        e.idx  = r;
        e.data = expRx;
        e.due  = hs + RSP_LAT;
        sb.push_back(e);
        @(posedge clk);
        #1;
        reqValid[r] = 1'b0;
    endtask

    task automatic waitCycle(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("scoreboard_drained", sb.size(), 0);
        repeat (4 * D + 2) @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN = 1'b0;
        repeat (2) @(negedge clk);
        rstN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int      hs, hs1, hs2, hs3, n;
        expRsp_t e;

        rstN     = 1'b0;
        reqValid = 2'b11;
        reqData  = '0;
        reqLast  = '0;
        misoMode = 0;
        bValid   = '0;
        bData    = '0;
        bLast    = '0;

        repeat (2) @(negedge clk);
        checkOutput("reset_sclk", 32'(sclk), 32'd0);
        checkOutput("reset_ss", 32'(ss), 32'd1);
        checkOutput("reset_mosi", 32'(mosi), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("reset_rsp_data", 32'(rspData), 32'd0);
        checkOutput("reset_ready_gated", 32'(reqReady), 32'd0);
        reqValid = 2'b00;
        rstN     = 1'b1;
        @(negedge clk);

        $display("[TB] single byte 0xA5 from req0");
        applyStimulus(0, 8'hA5, 1'b1, 8'hA5, hs);
        checkOutput("ss_fall_after_hs", 32'(ss), 32'd0);
        waitCycle(hs + RSP_LAT);
        checkOutput("mosi_bits", 32'(mosiCap), 32'hA5);
        waitCycle(hs + RSP_LAT + 1);
        checkOutput("ss_held_in_hold", 32'(ss), 32'd0);
        waitCycle(hs + 1 + 18 * D);
        checkOutput("ss_rise", 32'(ss), 32'd1);
        settle();

        $display("[TB] round-robin with both requesters valid");
        doReset();
        reqData  = {8'h22, 8'h11};
        reqLast  = 2'b11;
        reqValid = 2'b11;
        waitHandshake(hs1);
        checkOutput("rr_first", 32'(reqReady), 32'h1);
        e.idx = 0; e.data = 8'h11; e.due = hs1 + RSP_LAT; sb.push_back(e);
        @(posedge clk); #1;
        reqData[7:0] = 8'h33;
        waitHandshake(hs2);
        checkOutput("rr_second", 32'(reqReady), 32'h2);
        checkOutput("rr_regrant_cycle", hs2, hs1 + 1 + 19 * D);
        e.idx = 1; e.data = 8'h22; e.due = hs2 + RSP_LAT; sb.push_back(e);
        @(posedge clk); #1;
        reqValid[1] = 1'b0;
        waitHandshake(hs3);
        checkOutput("rr_third", 32'(reqReady), 32'h1);
        e.idx = 0; e.data = 8'h33; e.due = hs3 + RSP_LAT; sb.push_back(e);
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        settle();

        $display("[TB] burst 0x01,0x02,0x03 from req0 while req1 waits");
        doReset();
        reqData[15:8] = 8'h77;
        reqLast[1]    = 1'b1;
        reqValid[1]   = 1'b1;
        applyStimulus(0, 8'h01, 1'b0, 8'h01, hs1);
        watch = 1'b1;
        applyStimulus(0, 8'h02, 1'b0, 8'h02, hs2);
        applyStimulus(0, 8'h03, 1'b1, 8'h03, hs3);
        checkOutput("burst_back_to_back", hs2, hs1 + RSP_LAT);
        waitCycle(hs3 + RSP_LAT);
        watch = 1'b0;
        checkOutput("burst_ss_low", 32'(ssHighSeen), 32'd0);
        checkOutput("burst_req1_blocked", 32'(r1ReadySeen), 32'd0);
        waitHandshake(hs);
        checkOutput("req1_after_gap", 32'(reqReady), 32'h2);
        checkOutput("req1_grant_cycle", hs, hs3 + 1 + 19 * D);
        e.idx = 1; e.data = 8'h77; e.due = hs + RSP_LAT; sb.push_back(e);
        @(posedge clk); #1;
        reqValid[1] = 1'b0;
        settle();

        $display("[TB] reset during bit 4");
        reqData[7:0] = 8'hF0;
        reqLast[0]   = 1'b1;
        reqValid[0]  = 1'b1;
        waitHandshake(hs);
        @(posedge clk); #1;
        reqValid[0] = 1'b0;
        waitCycle(hs + 1 + D + 4 * 2 * D + D);
        checkOutput("bit4_sclk_high", 32'(sclk), 32'd1);
        checkOutput("bit4_ss_low", 32'(ss), 32'd0);
        #1;
        rstN = 1'b0;
        #1;
        checkOutput("abort_ss", 32'(ss), 32'd1);
        checkOutput("abort_sclk", 32'(sclk), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rspValid), 32'd0);
        checkOutput("abort_rsp_data", 32'(rspData), 32'd0);
        repeat (3) @(negedge clk);
        rstN = 1'b1;
        applyStimulus(1, 8'h5A, 1'b1, 8'h5A, hs);
        settle();

        $display("[TB] MISO tied high then low");
        misoMode = 1;
        applyStimulus(0, 8'h3C, 1'b1, 8'hFF, hs);
        settle();
        checkOutput("rsp_data_held_ff", 32'(rspData), 32'hFF);
        misoMode = 2;
        applyStimulus(0, 8'h3C, 1'b1, 8'h00, hs);
        settle();
        checkOutput("rsp_data_held_00", 32'(rspData), 32'h00);
        misoMode = 0;

        $display("[TB] CLK_DIV=1 instance echoes 0xC3");
        bData[7:0] = 8'hC3;
        bLast[0]   = 1'b1;
        bValid[0]  = 1'b1;
        #1;
        n = 0;
        while (!bReady[0] && n < 200) begin
            @(negedge clk);
            n++;
        end
        hs = cyc;
        checkOutput("fast_handshake", 32'(bReady), 32'h1);
        @(posedge clk); #1;
        bValid[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bRspValid == 2'b00 && n < 100);
        checkOutput("fast_rsp_cycle", cyc - hs, 18);
        checkOutput("fast_rsp_valid", 32'(bRspValid), 32'h1);
        checkOutput("fast_rsp_data", 32'(bRspData), 32'hC3);

        repeat (10) @(negedge clk);
        checkOutput("scoreboard_final", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_arbiter_master.md
# spi_arbiter_master

Single SPI master engine (mode 0, MSB first) shared between `NUM_REQ` on-chip requesters through round-robin arbitration. A requester owns the bus and holds `io_spi_ss` low for a multi-byte burst that it terminates with a `last` flag. The block sits between the SoC bus-side SPI clients (boot loader, peripheral driver) and the `io_spi0_*` pads of the Hydrogen top level.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 1..8.
- `CLK_DIV`, 4: SCLK half-period in `io_clock` cycles, ≥1.

Ports:
- `io_clock`  in  1  sole clock; every register is on its rising edge.
- `io_resetn`  in  1  asynchronous, active-low reset.
- `io_req_valid`  in  NUM_REQ  requester i offers a byte.
- `io_req_ready`  out  NUM_REQ  byte of requester i accepted this cycle.
- `io_req_data`  in  NUM_REQ*8  byte of requester i, bits [8i+7:8i].
- `io_req_last`  in  NUM_REQ  byte ends requester i's burst; SS released after it.
- `io_rsp_valid`  out  NUM_REQ  one-cycle pulse: received byte for requester i.
- `io_rsp_data`  out  8  received byte, valid with any `io_rsp_valid` bit.
- `io_spi_sclk`  out  1  SPI clock, idle low.
- `io_spi_ss`  out  1  slave select, active low.
- `io_spi_mosi`  out  1  master out.
- `io_spi_miso`  in  1  master in.

## Operation
- States: IDLE, SETUP, SHIFT, WAIT, HOLD, GAP.
- IDLE: round-robin pick among `io_req_valid`; highest priority goes to the index after the last granted one (requester 0 after reset). `io_req_ready[g]` is high combinationally for the winner g only. Handshake latches data/last, sets owner = g, advances the pointer → SETUP.
- SETUP: `ss`=0, `mosi`=bit7, `sclk`=0 for CLK_DIV cycles → SHIFT.
- SHIFT: 8 bits, each bit is CLK_DIV cycles `sclk` low then CLK_DIV cycles high. MISO is sampled into the rx shift register on the cycle `sclk` rises. MOSI advances to the next bit when `sclk` falls. After the 8th high phase, `sclk` returns low and `io_rsp_valid[owner]` pulses with `io_rsp_data` = rx byte. Then go to HOLD if last, else WAIT.
- WAIT: `ss` stays low and `sclk` stays low. Only the owner is considered; `io_req_ready[owner]` = `io_req_valid[owner]`. Handshake → SETUP. No timeout; other requesters are blocked.
- HOLD: `ss` low for CLK_DIV cycles → GAP.
- GAP: `ss` high for CLK_DIV cycles → IDLE.
- `io_req_ready` is all-zero outside IDLE/WAIT and while `io_resetn` is low.
- `io_rsp_data` holds its value until the next byte completes.

## Timing
- Reset values: `sclk`=0, `ss`=1, `mosi`=0, `io_rsp_valid`=0, `io_rsp_data`=0x00, state IDLE, RR pointer selects requester 0.
- Reset assertion mid-transfer: outputs take reset values asynchronously. No `io_rsp_valid` is issued for the aborted byte. The partial byte is dropped.
- Handshake to `ss` falling: 1 cycle.
- Handshake to `io_rsp_valid`: 1 + 17·CLK_DIV cycles.
- Burst byte-to-byte: the next handshake is possible in the same cycle as `io_rsp_valid`.
- Last byte: `ss` rises 1 + 18·CLK_DIV cycles after its handshake. The next grant is no earlier than CLK_DIV cycles after that.
- Simultaneous IDLE requests are resolved purely by the RR pointer.
- `io_req_valid` deasserted by a non-owner has no effect. Deassertion by the owner in WAIT keeps the bus held.

## Structure
- Package `spi_arb_pkg`: state enum `spi_arb_state_e`, `SPI_BITS`=8, and a function computing the next RR grant from the valid mask and pointer.
- Sub-module `spi_rr_arbiter`: combinational grant plus registered pointer with enable on handshake. Parameterised by NUM_REQ.
- Top-level keeps the FSM, the CLK_DIV counter (`$clog2(CLK_DIV+1)` bits), the bit counter (3 bits), and the tx/rx shift registers.

## Test plan
All scenarios use NUM_REQ=2, CLK_DIV=2, MISO looped to MOSI unless stated.
- Req0 sends 0xA5 with last=1 → MOSI is 1,0,1,0,0,1,0,1. `io_rsp_valid[0]` pulses once at cycle 35 after the handshake with `io_rsp_data`=0xA5. `ss` rises at cycle 37.
- Req0 and req1 valid together after reset → req0 is served first, then req1. A second simultaneous request → req1 first.
- Req0 sends a burst 0x01, 0x02, 0x03 (last on 0x03) while req1 is held valid → `ss` stays low across all 3 bytes and `io_req_ready[1]` stays 0. Req1 is granted only after GAP.
- MISO tied 1 then tied 0 (no loopback) → rx bytes 0xFF and 0x00 for data 0x3C.
- `io_resetn` pulsed low during bit 4 → `ss`=1 and `sclk`=0 immediately, with no rsp pulse. After release, req1 sends 0x5A and completes correctly.
- CLK_DIV=1 rebuild → SCLK period 2 cycles. Byte 0xC3 echoes back with rsp at cycle 18.
